apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB3 initiator (requester) that turns a single-entry valid/ready command interface into APB SETUP/ACCESS transfers.
- Drives one APB completer, honours PREADY wait states, and returns read data plus error status on a one-cycle response strobe.
- Sits between the internal control logic (bus bridge or test sequencer) and the APB peripheral fabric.
- Adds a programmable ACCESS-phase timeout so a hung completer cannot stall the requester.

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR.
- DATA_W, 32, width of the write/read data paths.
- TIMEOUT, 16, maximum number of ACCESS cycles before the transfer is aborted; 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; all logic is on the rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion strobe; no backpressure.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  completer ready.
- PSLVERR  in  1  completer error.

Behaviour:
- Reset values: all outputs are registered and reset to 0 (cmd_ready, rsp_*, PSEL, PENABLE, PWRITE, PADDR, PWDATA). The FSM resets to IDLE and the timeout counter to 0.
- Reset mid-transfer: asserting PRESETn low during SETUP or ACCESS drops PSEL and PENABLE immediately (asynchronously) and emits no response.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA; set PSEL = 1, PENABLE = 0; go to SETUP; cmd_ready goes to 0.
- SETUP: exactly one cycle. Set PENABLE = 1, clear the timeout counter, go to ACCESS.
- ACCESS, PREADY = 1 sampled:
  - Clear PSEL and PENABLE.
  - rsp_valid = 1 for one cycle.
  - rsp_err = PSLVERR.
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - rsp_timeout = 0.
  - Go to IDLE.
- ACCESS, PREADY = 0:
  - Increment the timeout counter.
  - If TIMEOUT != 0 and the counter equals TIMEOUT-1: clear PSEL and PENABLE; rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; go to IDLE.
  - If PREADY = 1 arrives in the same cycle the timeout would fire, normal completion wins.
- Stability: PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS. They keep their last value in IDLE and are not cleared.
- Ignored inputs: PREADY, PSLVERR and PRDATA are ignored outside ACCESS.
- Latency: acceptance edge E0 → SETUP. E1 → ACCESS. The first PREADY sample is at E2, so with zero wait states rsp_valid is high in the cycle after E2.
- Throughput: cmd_ready returns to 1 after the completion edge, so the next command is accepted no earlier than E3 (minimum 3 cycles per transfer). No direct ACCESS→SETUP chaining.
- Response hold: rsp_valid is a pulse. rsp_rdata, rsp_err and rsp_timeout hold their values until the next response.
- Counter width: $clog2(TIMEOUT+1). The counter saturates and never wraps.

Decomposition:
- Shared package apb_pkg:
  - apb_state_t enum (IDLE, SETUP, ACCESS).
  - APB_ADDR_W and APB_DATA_W default constants, also used by completer blocks.
  - Response status encoding constants (OK, SLVERR, TIMEOUT).
- No sub-module: the FSM and the timeout counter are inline. Expected size is about 150 RTL lines.

Test Plan:
- Zero-wait write: cmd write, addr 0x0000_0010, wdata 0xDEAD_BEEF; completer holds PREADY=1 → PSEL high 2 cycles, PENABLE high 1 cycle, PADDR/PWDATA stable throughout; rsp_valid pulse with rsp_err=0, rsp_rdata=0.
- Wait-state read: read addr 0x0000_0023; completer inserts 3 wait cycles, then PRDATA=0x1234_5678 with PREADY → PENABLE high 4 cycles; rsp_rdata=0x1234_5678; cmd_ready low for the whole transfer.
- Completer error: read addr 0x0001_0000 completes with PSLVERR=1 → rsp_err=1, rsp_timeout=0; the next command is accepted normally.
- Timeout: TIMEOUT=4, PREADY tied 0 → ACCESS lasts exactly 4 cycles, then PSEL=PENABLE=0; rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0. Also: PREADY=1 on the 4th ACCESS cycle → normal completion, rsp_timeout=0.
- Back-to-back: cmd_valid held high with 3 queued commands, zero-wait completer → exactly 3 transfers at a 3-cycle cadence, each command accepted once, in order.
- Reset mid-ACCESS: PRESETn low for 2 cycles during wait states → PSEL/PENABLE drop at once, no rsp_valid; after release, cmd_ready=1 and the next transfer is correct.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB initiator and any APB completer blocks:
//   - apb_state_t    : initiator transfer phase (IDLE / SETUP / ACCESS)
//   - APB_ADDR_W/_DW : default address and data widths of the fabric
//   - APB_RSP_*      : response status encoding (OK, SLVERR, TIMEOUT)
//   - apb_rsp_status : folds the err/timeout flags into that encoding
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [1:0] APB_RSP_OK      = 2'd0;
  localparam logic [1:0] APB_RSP_SLVERR  = 2'd1;
  localparam logic [1:0] APB_RSP_TIMEOUT = 2'd2;

  // Timeout takes precedence because a timed-out transfer also reports err.
  function automatic logic [1:0] apb_rsp_status(input logic err, input logic timeout);
    logic [1:0] status;
    if (timeout) begin
      status = APB_RSP_TIMEOUT;
    end else if (err) begin
      status = APB_RSP_SLVERR;
    end else begin
      status = APB_RSP_OK;
    end
    return status;
  endfunction

endpackage

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// APB3 initiator. Accepts one command at a time on a valid/ready interface,
// runs a SETUP + ACCESS transfer to a single completer, honours PREADY wait
// states, and reports completion on a one-cycle rsp_valid strobe. A bounded
// ACCESS phase (TIMEOUT cycles, 0 = unbounded) protects against hung
// completers.
//
// Ports:
//   PCLK, PRESETn            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command payload
//   rsp_valid                completion pulse (no backpressure)
//   rsp_rdata/err/timeout    completion status, held until the next response
//   PSEL..PWDATA             APB request outputs (all registered)
//   PRDATA/PREADY/PSLVERR    APB completer inputs, only looked at in ACCESS
// -----------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // Counter is at least one bit wide so TIMEOUT = 0 still elaborates.
  localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic             TO_EN    = (TIMEOUT != 0);

  apb_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              w_accept;
  logic              w_timeout_hit;

  // Handshake uses the registered ready, so acceptance only happens in IDLE.
  assign w_accept      = cmd_valid && r_cmd_ready;
  // Compared against the count before this cycle's increment, so the abort
  // lands on exactly the TIMEOUT-th ACCESS cycle.
  assign w_timeout_hit = TO_EN && (r_cnt == CNT_LAST);

  // Transfer FSM, timeout counter and all registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= {DATA_W{1'b0}};
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= {ADDR_W{1'b0}};
      r_pwdata      <= {DATA_W{1'b0}};
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_state     <= SETUP;
          end else begin
            // Also raises ready on the first cycle after reset.
            r_cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= {CNT_W{1'b0}};
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // A completing PREADY wins over a timeout in the same cycle.
          if (PREADY) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= PSLVERR;
            r_rsp_rdata   <= r_pwrite ? {DATA_W{1'b0}} : PRDATA;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= IDLE;
          end else if (w_timeout_hit) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_rdata   <= {DATA_W{1'b0}};
            r_rsp_timeout <= 1'b1;
            r_cmd_ready   <= 1'b1;
            r_state       <= IDLE;
          end else begin
            // Saturate so an unbounded wait (TIMEOUT = 0) never wraps.
            if (r_cnt != CNT_MAX) begin
              r_cnt <= r_cnt + CNT_ONE;
            end else begin
              r_cnt <= r_cnt;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Scoreboard bench for apb_master (TIMEOUT = 4). The stimulus side picks each
// command plus how the completer will answer it (wait cycles, read data,
// error) and pushes the expected response, computed from the transfer rules,
// into exp_q. A completer model plays the chosen answer on the APB pins, and
// an independent monitor pops exp_q whenever rsp_valid is seen.
// -----------------------------------------------------------------------------
module tb_apb_master;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          acc;
  } exp_t;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic        se;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    last_accept = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance with
  // cmd_valid still high so callers can chain commands back to back.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] rd, input logic se);
    exp_t  e;
    plan_t p;
    int    guard = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && guard < 200) begin
      @(negedge PCLK);
      guard++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_wait actual=not_accepted expected=accepted addr=0x%0h", a);
      cmd_valid = 1'b0;
      return;
    end
    p.waits = waits; p.rdata = rd; p.se = se;
    plan_q.push_back(p);
    e.wr = wr; e.addr = a; e.wdata = d;
    if (waits >= TO) begin
      e.rdata = 32'h0; e.err = 1'b1; e.to = 1'b1; e.acc = TO;
    end else begin
      e.rdata = wr ? 32'h0 : rd; e.err = se; e.to = 1'b0; e.acc = waits + 1;
    end
    exp_q.push_back(e);
    last_accept = cyc;
    @(negedge PCLK);
  endtask

  task automatic drain();
    int guard = 0;
    cmd_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge PCLK);
      guard++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    @(negedge PCLK);
  endtask

  // Completer model: plays the planned answer in ACCESS, noise elsewhere.
  initial begin
    plan_t cur;
    int    k = 0;
    cur.waits = 0; cur.rdata = 32'h0; cur.se = 1'b0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        PREADY = 1'b0; k = 0;
      end else if (PSEL && PENABLE) begin
        if (k == cur.waits) begin
          PREADY = 1'b1; PRDATA = cur.rdata; PSLVERR = cur.se;
        end else begin
          PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
        k++;
      end else begin
        if (PSEL) begin
          if (plan_q.size() != 0) cur = plan_q.pop_front();
          k = 0;
        end
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
    end
  end

  // Monitor: protocol shape per transfer plus response scoreboard.
  initial begin
    exp_t e;
    int   psel_n = 0;
    int   pen_n = 0;
    bit   bad = 1'b0;
    bit   prev_v = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        psel_n = 0; pen_n = 0; bad = 1'b0; prev_v = 1'b0;
      end else begin
        if (PSEL) begin
          psel_n++;
          if (PENABLE) pen_n++;
          if (exp_q.size() == 0) bad = 1'b1;
          else if (PADDR !== exp_q[0].addr || PWRITE !== exp_q[0].wr ||
                   PWDATA !== exp_q[0].wdata || cmd_ready !== 1'b0) bad = 1'b1;
        end
        if (rsp_valid) begin
          chk("rsp_pulse_prev", 64'(prev_v), 64'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rsp actual=rsp_valid expected=none");
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
            chk("access_cycles", 64'(pen_n), 64'(e.acc));
            chk("psel_cycles", 64'(psel_n), 64'(e.acc + 1));
            chk("req_stable", 64'(bad), 64'd0);
            chk("paddr_hold", 64'(PADDR), 64'(e.addr));
            chk("psel_dropped", 64'({PSEL, PENABLE}), 64'd0);
          end
          psel_n = 0; pen_n = 0; bad = 1'b0;
        end
        prev_v = rsp_valid;
      end
    end
  end

  initial begin
    int t0, t1, t2, guard;
    PRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    repeat (3) @(negedge PCLK);
    chk("rst_ctrl", 64'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, PSEL, PENABLE, PWRITE}), 64'd0);
    chk("rst_paddr", 64'(PADDR), 64'd0);
    chk("rst_pwdata", 64'(PWDATA), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Zero-wait write, wait-state read, completer error, follow-up write.
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 1'b0); drain();
    send(1'b0, 32'h0000_0023, 32'h0BAD_0BAD, 3, 32'h1234_5678, 1'b0); drain();
    send(1'b0, 32'h0001_0000, 32'h0, 0, 32'hCAFE_F00D, 1'b1);         drain();
    send(1'b1, 32'h0000_0044, 32'h5555_AAAA, 1, 32'h0, 1'b0);          drain();
    // Timeout, then PREADY on the last allowed ACCESS cycle.
    send(1'b0, 32'h0000_0100, 32'h0, 99, 32'h7777_7777, 1'b0);         drain();
    send(1'b0, 32'h0000_0104, 32'h0, TO - 1, 32'h8888_0001, 1'b0);     drain();

    // Back-to-back with cmd_valid held high.
    send(1'b1, 32'h0000_0200, 32'h1111_1111, 0, 32'h0, 1'b0); t0 = last_accept;
    send(1'b0, 32'h0000_0204, 32'h2222_2222, 0, 32'h3333_3333, 1'b0); t1 = last_accept;
    send(1'b1, 32'h0000_0208, 32'h4444_4444, 0, 32'h0, 1'b0); t2 = last_accept;
    drain();
    chk("b2b_gap1", 64'(t1 - t0), 64'd3);
    chk("b2b_gap2", 64'(t2 - t1), 64'd3);

    // Reset during ACCESS wait states.
    send(1'b0, 32'h0000_0300, 32'h0, 99, 32'h0, 1'b0);
    cmd_valid = 1'b0;
    guard = 0;
    while (!(PSEL && PENABLE) && guard < 20) begin
      @(negedge PCLK);
      guard++;
    end
    chk("reach_access", 64'({PSEL, PENABLE}), 64'd3);
    @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1 chk("rst_drop_psel", 64'({PSEL, PENABLE}), 64'd0);
    exp_q.delete();
    plan_q.delete();
    @(negedge PCLK);
    @(negedge PCLK);
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("ready_after_midrst", 64'(cmd_ready), 64'd1);
    send(1'b0, 32'h0000_0400, 32'h0, 2, 32'hABCD_0123, 1'b0); drain();

    // Randomized traffic, including timeouts and back-to-back bursts.
    for (int i = 0; i < 60; i++) begin
      send(1'($urandom), $urandom, $urandom, $urandom_range(0, 5), $urandom,
           1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge PCLK);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
